wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback arbiter that sits directly upstream of the register file's single write port; it drives the regfile's write address, write data and write enable.
- Merges two result sources into one write per cycle:
  - the in-order pipeline writeback, which has fixed priority and is never stalled by this block;
  - a long-latency unit (divider/multiplier) result stream with a valid/ready handshake, buffered in a small FIFO.
- Provides a starvation request so the pipeline can insert a bubble when buffered results wait too long.

Parameters:
- WORD, 32, data width; matches the regfile word.
- REG_SIZE, 5, register address width.
- FIFO_DEPTH, 4, long-latency result buffer entries; power of two, at least 2.
- STARVE_LIMIT, 8, cycles the FIFO head may wait before pipe_stall asserts; range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pipe_we  in  1  pipeline writeback request.
- pipe_waddr  in  REG_SIZE  pipeline destination register.
- pipe_wdata  in  WORD  pipeline result.
- ltu_valid  in  1  long-latency result valid.
- ltu_waddr  in  REG_SIZE  long-latency destination register.
- ltu_wdata  in  WORD  long-latency result.
- ltu_ready  out  1  FIFO can accept a result.
- wb_en  out  1  regfile write enable (regWrite).
- wb_addr  out  REG_SIZE  regfile write address (raddr3).
- wb_data  out  WORD  regfile write data.
- pipe_stall  out  1  request for the pipeline to withhold writeback next cycle.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, rst=1):
  - wb_en=0, wb_addr=0, wb_data=0.
  - FIFO emptied: pointers=0, fifo_level=0.
  - Starvation counter=0, pipe_stall=0, ltu_ready=1 immediately.
- Reset asserted mid-operation discards all buffered results. No write is issued during reset or in the first edge after release unless the inputs request one.
- wb_en, wb_addr and wb_data are registered: a decision made in cycle t is visible in t+1 and is written by the regfile at the t+1 edge.
- Per-cycle priority:
  1. pipe_we=1 and pipe_waddr!=0: register the pipeline write; the FIFO does not pop.
  2. Otherwise, FIFO non-empty: pop the head and register it as the write.
  3. Otherwise: wb_en<=0; wb_addr and wb_data hold their previous values.
- Writes to register 0 are never issued:
  - pipe_we with pipe_waddr=0 is treated as no pipeline request, so the FIFO may drain that cycle.
  - An ltu result with ltu_waddr=0 is handshaken (consumed) but not pushed.
- Handshake:
  - ltu_ready = (fifo_level != FIFO_DEPTH), computed from registered state only.
  - A transfer occurs when ltu_valid && ltu_ready.
  - The source holds valid and payload stable until the transfer occurs.
- Full FIFO with a pop in the same cycle: ltu_ready stays 0 that cycle (no same-cycle slot reuse); ready rises the next cycle.
- Empty FIFO with a push and no pipeline write: no bypass. The pushed entry is popped the next cycle, so wb_en appears at t+2.
- Push and pop in the same cycle: fifo_level unchanged; pointers wrap modulo FIFO_DEPTH.
- Ordering: FIFO entries leave in arrival order. WAW hazards between the two sources are the scoreboard's responsibility and are not checked here.

Optional Feature:
- Macro: WB_STARVE_EN.
- Defined:
  - 8-bit starvation counter increments each cycle the FIFO is non-empty and does not pop, saturating at 255.
  - Counter clears on any pop or when the FIFO is empty.
  - pipe_stall = (counter >= STARVE_LIMIT), combinational from the register.
  - The next pop clears the counter, so pipe_stall deasserts the cycle after the drain.
- Not defined: no counter is instantiated, pipe_stall is tied to 0, and the FIFO drains only in pipeline-idle cycles.

Test Plan:
- Reset, then pipe_we=1, pipe_waddr=3, pipe_wdata=0xA5 in cycle 1 -> cycle 2: wb_en=1, wb_addr=3, wb_data=0xA5; cycle 3 with pipe_we=0: wb_en=0.
- pipe_we=1 every cycle for 3 cycles (addr 4); ltu pushes addr 7 data 0x11 in cycle 0 -> fifo_level=1 while the pipeline writes; addr 7 / 0x11 appears the cycle after pipe_we first drops; fifo_level returns to 0.
- Keep pipe_we=1 and push 4 ltu results -> ltu_ready=0 after the 4th; a 5th ltu_valid is held and not lost; after pipe_we drops, results drain in order, one per cycle, and ltu_ready=1 one cycle after the first pop.
- ltu_waddr=0 with ltu_valid=1 -> handshake completes, fifo_level stays 0, no wb_en. pipe_we=1 with pipe_waddr=0 and FIFO holding 1 entry -> the FIFO entry is written instead.
- WB_STARVE_EN, STARVE_LIMIT=8: FIFO holds 1 entry with pipe_we=1 continuously -> pipe_stall=1 after 8 waiting cycles; drop pipe_we -> entry written, pipe_stall=0 the following cycle.
- Assert rst asynchronously mid-drain with 3 entries -> wb_en=0 and fifo_level=0 without a clock edge; no stale entries are written after release.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter feeding the register file's single write port.
// The in-order pipeline writeback always wins. Long-latency results are
// queued in a small FIFO and drain in cycles the pipeline leaves idle.
// Optional build macro: WB_STARVE_EN enables the starvation counter that
// drives pipe_stall; without it pipe_stall is tied low.
module wb_arbiter #(
  parameter int WORD         = 32,
  parameter int REG_SIZE     = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pipe_we,
  input  logic [REG_SIZE-1:0]           pipe_waddr,
  input  logic [WORD-1:0]               pipe_wdata,
  input  logic                          ltu_valid,
  input  logic [REG_SIZE-1:0]           ltu_waddr,
  input  logic [WORD-1:0]               ltu_wdata,
  output logic                          ltu_ready,
  output logic                          wb_en,
  output logic [REG_SIZE-1:0]           wb_addr,
  output logic [WORD-1:0]               wb_data,
  output logic                          pipe_stall,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [REG_SIZE-1:0] r_addr_mem [FIFO_DEPTH];
  logic [WORD-1:0]     r_data_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [LW-1:0]       r_level;

  logic w_pipe_req;
  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  // Register 0 is never written: a pipeline write to r0 counts as no request,
  // and a long-latency result for r0 is accepted by the handshake but dropped.
  assign w_pipe_req = pipe_we && (pipe_waddr != '0);
  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == LW'(FIFO_DEPTH));
  // Ready depends only on registered occupancy, so a slot freed by a pop
  // becomes visible to the source one cycle later.
  assign ltu_ready  = !w_full;
  assign w_push     = ltu_valid && ltu_ready && (ltu_waddr != '0);
  assign w_pop      = !w_pipe_req && !w_empty;
  assign fifo_level = r_level;

  // FIFO storage: payload only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_mem[r_wptr] <= ltu_waddr;
      r_data_mem[r_wptr] <= ltu_wdata;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (depth is a power of two).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Registered write port: pipeline first, then FIFO head, else idle with
  // address/data holding their last values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (w_pipe_req) begin
      wb_en   <= 1'b1;
      wb_addr <= pipe_waddr;
      wb_data <= pipe_wdata;
    end else if (w_pop) begin
      wb_en   <= 1'b1;
      wb_addr <= r_addr_mem[r_rptr];
      wb_data <= r_data_mem[r_rptr];
    end else begin
      wb_en   <= 1'b0;
    end
  end

`ifdef WB_STARVE_EN
  logic [7:0] r_starve;

  // Count cycles the FIFO head waits behind the pipeline; saturates at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_empty || w_pop) begin
      r_starve <= '0;
    end else if (r_starve != 8'hFF) begin
      r_starve <= r_starve + 8'd1;
    end
  end

  assign pipe_stall = (r_starve >= 8'(STARVE_LIMIT));
`else
  assign pipe_stall = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed stimulus; expected writes are queued and a
// monitor compares every regfile write the DUT issues against the queue.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        ltu_valid;
  logic [4:0]  ltu_waddr;
  logic [31:0] ltu_wdata;
  logic        ltu_ready;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        pipe_stall;
  logic [2:0]  fifo_level;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  wb_arbiter #(
    .WORD(32), .REG_SIZE(5), .FIFO_DEPTH(4), .STARVE_LIMIT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .ltu_valid(ltu_valid), .ltu_waddr(ltu_waddr), .ltu_wdata(ltu_wdata),
    .ltu_ready(ltu_ready),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .pipe_stall(pipe_stall), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back('{a: a, d: d});
  endtask

  // Monitor: every issued write must match the next queued expectation.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (wb_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%0h:%0h expected=none", wb_addr, wb_data);
        end else begin
          e = exp_q.pop_front();
          chk("wb_addr", 32'(wb_addr), 32'(e.a));
          chk("wb_data", wb_data, e.d);
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    ltu_valid = 1'b0; ltu_waddr = '0; ltu_wdata = '0;

    // Reset state
    tick();
    chk("rst_wb_en",   32'(wb_en), 32'd0);
    chk("rst_wb_addr", 32'(wb_addr), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_level",   32'(fifo_level), 32'd0);
    chk("rst_ready",   32'(ltu_ready), 32'd1);
    chk("rst_stall",   32'(pipe_stall), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_wb_en", 32'(wb_en), 32'd0);

    // Single pipeline write, visible one cycle later, then idle holds addr/data
    pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'hA5;
    exp_wr(5'd3, 32'hA5);
    tick();
    chk("t1_wb_en", 32'(wb_en), 32'd1);
    chk("t1_addr",  32'(wb_addr), 32'd3);
    chk("t1_data",  wb_data, 32'hA5);
    pipe_we = 1'b0;
    tick();
    chk("t1_idle_en",   32'(wb_en), 32'd0);
    chk("t1_hold_addr", 32'(wb_addr), 32'd3);
    chk("t1_hold_data", wb_data, 32'hA5);

    // Pipeline owns the port for 3 cycles while one ltu result waits
    pipe_we = 1'b1; pipe_waddr = 5'd4; pipe_wdata = 32'h40;
    ltu_valid = 1'b1; ltu_waddr = 5'd7; ltu_wdata = 32'h11;
    exp_wr(5'd4, 32'h40);
    tick();
    ltu_valid = 1'b0;
    chk("t2_level_a", 32'(fifo_level), 32'd1);
    pipe_wdata = 32'h41; exp_wr(5'd4, 32'h41);
    tick();
    chk("t2_level_b", 32'(fifo_level), 32'd1);
    pipe_wdata = 32'h42; exp_wr(5'd4, 32'h42);
    tick();
    chk("t2_level_c", 32'(fifo_level), 32'd1);
    pipe_we = 1'b0;
    exp_wr(5'd7, 32'h11);
    tick();
    chk("t2_drain_en",   32'(wb_en), 32'd1);
    chk("t2_drain_addr", 32'(wb_addr), 32'd7);
    chk("t2_level_0",    32'(fifo_level), 32'd0);
    tick();
    chk("t2_idle_en", 32'(wb_en), 32'd0);

    // Fill the FIFO behind a busy pipeline; a fifth result must be held
    for (int i = 0; i < 4; i++) begin
      pipe_we = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'h50 + 32'(i);
      exp_wr(5'd5, 32'h50 + 32'(i));
      ltu_valid = 1'b1; ltu_waddr = 5'd8 + 5'(i); ltu_wdata = 32'h80 + 32'(i);
      chk("t3_ready_fill", 32'(ltu_ready), 32'd1);
      tick();
    end
    chk("t3_full_ready", 32'(ltu_ready), 32'd0);
    chk("t3_full_level", 32'(fifo_level), 32'd4);
    ltu_waddr = 5'd12; ltu_wdata = 32'h84;
    pipe_wdata = 32'h54; exp_wr(5'd5, 32'h54);
    tick();
    chk("t3_held_ready", 32'(ltu_ready), 32'd0);
    chk("t3_held_level", 32'(fifo_level), 32'd4);
    pipe_we = 1'b0;
    for (int i = 0; i < 5; i++) exp_wr(5'd8 + 5'(i), 32'h80 + 32'(i));
    tick();
    chk("t3_ready_back", 32'(ltu_ready), 32'd1);
    chk("t3_level_3",    32'(fifo_level), 32'd3);
    chk("t3_drain_en0",  32'(wb_en), 32'd1);
    tick();
    ltu_valid = 1'b0;
    chk("t3_level_pushpop", 32'(fifo_level), 32'd3);
    chk("t3_drain_en1",     32'(wb_en), 32'd1);
    for (int i = 2; i < 5; i++) begin
      tick();
      chk("t3_drain_en", 32'(wb_en), 32'd1);
    end
    chk("t3_level_empty", 32'(fifo_level), 32'd0);
    tick();
    chk("t3_idle_en", 32'(wb_en), 32'd0);

    // ltu result for r0 is consumed but dropped
    ltu_valid = 1'b1; ltu_waddr = 5'd0; ltu_wdata = 32'hDEAD;
    chk("t4_r0_ready", 32'(ltu_ready), 32'd1);
    tick();
    ltu_valid = 1'b0;
    chk("t4_r0_level", 32'(fifo_level), 32'd0);
    tick();
    chk("t4_r0_no_wr", 32'(wb_en), 32'd0);

    // Pipeline write to r0 lets the FIFO drain instead
    pipe_we = 1'b1; pipe_waddr = 5'd6; pipe_wdata = 32'h66;
    exp_wr(5'd6, 32'h66);
    ltu_valid = 1'b1; ltu_waddr = 5'd9; ltu_wdata = 32'h99;
    tick();
    ltu_valid = 1'b0;
    pipe_waddr = 5'd0; pipe_wdata = 32'hBAD;
    exp_wr(5'd9, 32'h99);
    chk("t4_p0_level", 32'(fifo_level), 32'd1);
    tick();
    chk("t4_p0_en",    32'(wb_en), 32'd1);
    chk("t4_p0_addr",  32'(wb_addr), 32'd9);
    chk("t4_p0_level0", 32'(fifo_level), 32'd0);
    pipe_we = 1'b0;
    tick();
    chk("t4_p0_idle", 32'(wb_en), 32'd0);

    // Starvation: one entry waits behind a continuously busy pipeline
    pipe_we = 1'b1; pipe_waddr = 5'd2; pipe_wdata = 32'h20;
    exp_wr(5'd2, 32'h20);
    ltu_valid = 1'b1; ltu_waddr = 5'd13; ltu_wdata = 32'h0D;
    tick();
    ltu_valid = 1'b0;
    chk("t5_stall_0", 32'(pipe_stall), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      logic exp_stall;
      pipe_wdata = 32'h20 + 32'(k);
      exp_wr(5'd2, 32'h20 + 32'(k));
      tick();
`ifdef WB_STARVE_EN
      exp_stall = (k >= 8);
`else
      exp_stall = 1'b0;
`endif
      chk("t5_stall_wait", 32'(pipe_stall), 32'(exp_stall));
    end
    pipe_we = 1'b0;
    exp_wr(5'd13, 32'h0D);
    tick();
    chk("t5_stall_clr", 32'(pipe_stall), 32'd0);
    chk("t5_drain_en",  32'(wb_en), 32'd1);
    chk("t5_drain_addr", 32'(wb_addr), 32'd13);
    tick();

    // Asynchronous reset in the middle of a drain
    for (int i = 0; i < 3; i++) begin
      pipe_we = 1'b1; pipe_waddr = 5'd1; pipe_wdata = 32'h10 + 32'(i);
      exp_wr(5'd1, 32'h10 + 32'(i));
      ltu_valid = 1'b1; ltu_waddr = 5'd20 + 5'(i); ltu_wdata = 32'hC0 + 32'(i);
      tick();
    end
    ltu_valid = 1'b0;
    pipe_we = 1'b0;
    exp_wr(5'd20, 32'hC0);
    chk("t6_level_3", 32'(fifo_level), 32'd3);
    tick();
    chk("t6_level_2", 32'(fifo_level), 32'd2);
    chk("t6_drain_en", 32'(wb_en), 32'd1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_async_en",    32'(wb_en), 32'd0);
    chk("t6_async_level", 32'(fifo_level), 32'd0);
    chk("t6_async_addr",  32'(wb_addr), 32'd0);
    chk("t6_async_ready", 32'(ltu_ready), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_no_stale_en", 32'(wb_en), 32'd0);
    end
    chk("t6_level_after", 32'(fifo_level), 32'd0);

    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
